// File: rtl/instr_register_pkg.sv
// ----------------------------------------------------------------------------
// instr_register_pkg
// Shared types for the instruction register and its readback checker:
//   operand_t, result_t, address_t, opcode_t, instruction_t, readback_state_t
//   plus a helper that clamps a requested scan length to the array depth.
// opcode_t is 4 bits wide so that encodings 8..15 exist and can be flagged
// as unknown by the readback model.
// ----------------------------------------------------------------------------
package instr_register_pkg;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic        [4:0]  address_t;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  result;
    } instruction_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_OUT   = 2'd2,
        ST_DONE  = 2'd3
    } readback_state_t;

    // A scan never covers more than the 32 entries of the register array.
    function automatic logic [5:0] clamp_count(input logic [5:0] cnt);
        if (cnt > 6'd32) begin
            return 6'd32;
        end else begin
            return cnt;
        end
    endfunction

endpackage

// File: rtl/instr_result_model.sv
// ----------------------------------------------------------------------------
// instr_result_model
// Purely combinational reference model of the instruction ALU. Only compiled
// when READBACK_CHECK_EN is defined (it is instantiated only in that build).
// Ports:
//   instr_i   : instruction entry (opcode, signed operands)
//   result_o  : recomputed signed 64-bit result
//   invalid_o : opcode is not one of the defined encodings
// ----------------------------------------------------------------------------
`ifdef READBACK_CHECK_EN
module instr_result_model
    import instr_register_pkg::*;
(
    input  instruction_t instr_i,
    output result_t      result_o,
    output logic         invalid_o
);

    // Local signed copies so every operation below is a signed operation.
    operand_t a_s;
    operand_t b_s;

    assign a_s = instr_i.op_a;
    assign b_s = instr_i.op_b;

    // Result computation per opcode; divide/modulo by zero yield 0.
    always_comb begin
        result_o  = '0;
        invalid_o = 1'b0;
        case (instr_i.opc)
            ZERO:  result_o = '0;
            PASSA: result_o = result_t'(a_s);
            PASSB: result_o = result_t'(b_s);
            ADD:   result_o = result_t'(a_s) + result_t'(b_s);
            SUB:   result_o = result_t'(a_s) - result_t'(b_s);
            MULT:  result_o = result_t'(a_s) * result_t'(b_s);
            DIV: begin
                if (b_s == 32'sd0) begin
                    result_o = '0;
                end else begin
                    result_o = result_t'(a_s / b_s);
                end
            end
            MOD: begin
                if (b_s == 32'sd0) begin
                    result_o = '0;
                end else begin
                    result_o = result_t'(a_s % b_s);
                end
            end
            default: begin
                result_o  = '0;
                invalid_o = 1'b1;
            end
        endcase
    end

endmodule
`endif

// File: rtl/instr_readback_checker.sv
// ----------------------------------------------------------------------------
// instr_readback_checker
// Walks a range of instruction-register entries, captures each entry and
// presents it on a valid/ready stream together with a recomputed result and
// a mismatch flag.
// Build option: READBACK_CHECK_EN compiles in the result model. Without it,
// out_expected, out_mismatch and error_count read as zero.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   start, first_ptr,
//   count                : scan request (count 1..32, larger is clamped)
//   read_pointer         : index into the register array
//   instruction_word     : entry at read_pointer (combinational)
//   out_valid/out_ready  : output stream handshake
//   out_instr,
//   out_expected,
//   out_mismatch         : beat payload
//   busy, done           : scan status, done is a one-cycle pulse
//   error_count          : saturating count of accepted mismatched beats
// ----------------------------------------------------------------------------
module instr_readback_checker
    import instr_register_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  address_t             first_ptr,
    input  logic [5:0]           count,
    output address_t             read_pointer,
    input  instruction_t         instruction_word,
    output logic                 out_valid,
    input  logic                 out_ready,
    output instruction_t         out_instr,
    output result_t              out_expected,
    output logic                 out_mismatch,
    output logic                 busy,
    output logic                 done,
    output logic [ERR_CNT_W-1:0] error_count
);

    readback_state_t      state_q;
    address_t             read_pointer_q;
    logic [5:0]           remaining_q;
    logic                 out_valid_q;
    instruction_t         out_instr_q;
    result_t              out_expected_q;
    logic                 out_mismatch_q;
    logic                 busy_q;
    logic                 done_q;
    logic [ERR_CNT_W-1:0] error_count_q;

    result_t              expected_s;
    logic                 mismatch_s;

`ifdef READBACK_CHECK_EN
    result_t model_result_s;
    logic    model_invalid_s;

    instr_result_model u_model (
        .instr_i   (instruction_word),
        .result_o  (model_result_s),
        .invalid_o (model_invalid_s)
    );

    assign expected_s = model_result_s;
    // An unknown opcode always flags, even if the stored result happens to be 0.
    assign mismatch_s = model_invalid_s | (instruction_word.result != model_result_s);
`else
    assign expected_s = '0;
    assign mismatch_s = 1'b0;
`endif

    // Scan FSM; read_pointer_q doubles as the scan pointer and only moves on
    // entry to FETCH, so it is stable for the register while a beat is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            read_pointer_q <= 5'd0;
            remaining_q    <= 6'd0;
            out_valid_q    <= 1'b0;
            out_instr_q    <= '0;
            out_expected_q <= '0;
            out_mismatch_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_count_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start && (count != 6'd0)) begin
                        read_pointer_q <= first_ptr;
                        remaining_q    <= clamp_count(count);
                        error_count_q  <= '0;
                        busy_q         <= 1'b1;
                        state_q        <= ST_FETCH;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    out_instr_q    <= instruction_word;
                    out_expected_q <= expected_s;
                    out_mismatch_q <= mismatch_s;
                    out_valid_q    <= 1'b1;
                    state_q        <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_mismatch_q && (error_count_q != {ERR_CNT_W{1'b1}})) begin
                            error_count_q <= error_count_q + ERR_CNT_W'(1);
                        end else begin
                            error_count_q <= error_count_q;
                        end
                        remaining_q <= remaining_q - 6'd1;
                        if (remaining_q == 6'd1) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            read_pointer_q <= read_pointer_q + 5'd1;
                            state_q        <= ST_FETCH;
                        end
                    end else begin
                        state_q <= ST_OUT;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign read_pointer = read_pointer_q;
    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_expected = out_expected_q;
    assign out_mismatch = out_mismatch_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error_count  = error_count_q;

endmodule
